// File: rtl/k12a_mem_arbiter.sv
// rtl/k12a_mem_arbiter.sv - CPU/DMA single-port memory arbiter; `K12A_ARB_STARVE_EN enables the DMA starvation steal
package k12a_mem_pkg;
    typedef enum logic {
        MEM_MODE_READ  = 1'b0,
        MEM_MODE_WRITE = 1'b1
    } mem_mode_t;
endpackage

module k12a_mem_arbiter
    import k12a_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_mem_enable,
    input  mem_mode_t   cpu_mem_mode,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_write,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        mem_enable,
    output mem_mode_t   mem_mode,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;
    logic        steal;
    logic        dma_grant;

    // Legal STARVE_LIMIT is 1..15; this block only exists for an illegal setting.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
    end

`ifdef K12A_ARB_STARVE_EN
    localparam logic [3:0] STEAL_AT = 4'(STARVE_LIMIT - 1);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        steal = (state_q == ST_WAIT) && dma_req && cpu_mem_enable
                && (starve_cnt_q == STEAL_AT);
    end

    // Counts only CPU-blocked WAIT cycles; any grant, abandon or other state clears it.
    always_comb begin
        starve_cnt_d = 4'd0;
        if ((state_q == ST_WAIT) && dma_req && cpu_mem_enable && !steal) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
        end
    end
`else
    always_comb begin
        steal = 1'b0;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dma_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_req) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!dma_req) begin
                    state_d = ST_IDLE;
                end else if (!cpu_mem_enable || steal) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset gates every bus-visible effect, including a grant from a WAIT state caught mid-reset.
    always_comb begin
        dma_grant   = reset_n && (state_q == ST_WAIT) && dma_req && (!cpu_mem_enable || steal);
        dma_ack     = reset_n && (state_q == ST_DONE);
        cpu_stall   = reset_n && steal;
        dma_rdata_d = dma_rdata_q;
        mem_mode    = cpu_mem_mode;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        mem_enable  = reset_n && cpu_mem_enable;
        if (dma_grant) begin
            mem_enable = 1'b1;
            mem_mode   = dma_write ? MEM_MODE_WRITE : MEM_MODE_READ;
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            if (!dma_write) begin
                dma_rdata_d = mem_rdata;
            end
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// tb/tb_k12a_mem_arbiter.sv - directed self-checking bench for k12a_mem_arbiter (STARVE_LIMIT=4)
module tb_k12a_mem_arbiter;
    import k12a_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_mem_enable;
    mem_mode_t   cpu_mem_mode;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_write;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        mem_enable;
    mem_mode_t   mem_mode;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [15:0] last_wr_addr = 16'h0000;
    logic [7:0]  last_wr_data = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    k12a_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cpu_mem_enable (cpu_mem_enable),
        .cpu_mem_mode   (cpu_mem_mode),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .dma_req        (dma_req),
        .dma_write      (dma_write),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_ack        (dma_ack),
        .dma_rdata      (dma_rdata),
        .mem_enable     (mem_enable),
        .mem_mode       (mem_mode),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clock = ~clock;

    // Fixed-content memory: a few known locations, everything else reads zero.
    always_comb begin
        case (mem_addr)
            16'h1234: mem_rdata = 8'hA5;
            16'h0099: mem_rdata = 8'h5A;
            16'h2000: mem_rdata = 8'hC3;
            default:  mem_rdata = 8'h00;
        endcase
    end

    always @(posedge clock) begin
        if (mem_enable && mem_mode == MEM_MODE_WRITE) begin
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        cpu_mem_enable = 1'b1;
        cpu_mem_mode   = MEM_MODE_READ;
        cpu_addr       = 16'h1234;
        cpu_wdata      = 8'h00;
        dma_req        = 1'b1;
        dma_write      = 1'b0;
        dma_addr       = 16'h0000;
        dma_wdata      = 8'h00;
        step();
        step();
        mid();
        n_cmp++;
        if ({dma_ack, cpu_stall, mem_enable} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_outputs: ack/stall/en got %b want 000", {dma_ack, cpu_stall, mem_enable});
        end
        n_cmp++;
        if (dma_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL rst_dma_rdata: got %h want 00", dma_rdata);
        end
        n_cmp++;
        if ({mem_addr, cpu_rdata} !== {16'h1234, 8'hA5}) begin
            n_err++;
            $display("FAIL rst_cpu_path: addr/rdata got %h want 1234a5", {mem_addr, cpu_rdata});
        end
        step();
        reset_n        = 1'b1;
        dma_req        = 1'b0;
        cpu_mem_enable = 1'b0;
        mid();
        n_cmp++;
        if ({dma_ack, cpu_stall, mem_enable} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_release: ack/stall/en got %b want 000", {dma_ack, cpu_stall, mem_enable});
        end
    endtask

    task automatic test_passthrough();
        step();
        cpu_mem_enable = 1'b1;
        cpu_mem_mode   = MEM_MODE_WRITE;
        cpu_addr       = 16'h5555;
        cpu_wdata      = 8'h77;
        mid();
        n_cmp++;
        if ({mem_enable, mem_mode, mem_addr, mem_wdata, cpu_stall} !== {1'b1, MEM_MODE_WRITE, 16'h5555, 8'h77, 1'b0}) begin
            n_err++;
            $display("FAIL cpu_pass: got %h want %h", {mem_enable, mem_mode, mem_addr, mem_wdata, cpu_stall},
                     {1'b1, MEM_MODE_WRITE, 16'h5555, 8'h77, 1'b0});
        end
        step();
        cpu_mem_enable = 1'b0;
        cpu_mem_mode   = MEM_MODE_READ;
    endtask

    task automatic test_dma_read();
        step();
        dma_req   = 1'b1;
        dma_write = 1'b0;
        dma_addr  = 16'h1234;
        mid();
        n_cmp++;
        if ({mem_enable, dma_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL rd_idle: en/ack got %b want 00", {mem_enable, dma_ack});
        end
        step();
        mid();
        n_cmp++;
        if ({mem_enable, mem_mode, mem_addr, dma_ack, cpu_stall} !== {1'b1, MEM_MODE_READ, 16'h1234, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rd_access: got %h want %h", {mem_enable, mem_mode, mem_addr, dma_ack, cpu_stall},
                     {1'b1, MEM_MODE_READ, 16'h1234, 1'b0, 1'b0});
        end
        step();
        dma_req = 1'b0;
        mid();
        n_cmp++;
        if ({dma_ack, dma_rdata, mem_enable} !== {1'b1, 8'hA5, 1'b0}) begin
            n_err++;
            $display("FAIL rd_ack: ack/rdata/en got %h want 1a50", {dma_ack, dma_rdata, mem_enable});
        end
        step();
        mid();
        n_cmp++;
        if ({dma_ack, dma_rdata} !== {1'b0, 8'hA5}) begin
            n_err++;
            $display("FAIL rd_after: ack/rdata got %h want 0a5", {dma_ack, dma_rdata});
        end
    endtask

    task automatic test_dma_write();
        step();
        dma_req   = 1'b1;
        dma_write = 1'b1;
        dma_addr  = 16'h0040;
        dma_wdata = 8'h3C;
        mid();
        step();
        mid();
        n_cmp++;
        if ({mem_enable, mem_mode, mem_addr, mem_wdata} !== {1'b1, MEM_MODE_WRITE, 16'h0040, 8'h3C}) begin
            n_err++;
            $display("FAIL wr_access: got %h want %h", {mem_enable, mem_mode, mem_addr, mem_wdata},
                     {1'b1, MEM_MODE_WRITE, 16'h0040, 8'h3C});
        end
        step();
        dma_req = 1'b0;
        mid();
        n_cmp++;
        if ({dma_ack, dma_rdata} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL wr_ack: ack/rdata got %h want 1a5", {dma_ack, dma_rdata});
        end
        n_cmp++;
        if ({last_wr_addr, last_wr_data} !== {16'h0040, 8'h3C}) begin
            n_err++;
            $display("FAIL wr_memory: addr/data got %h want 00403c", {last_wr_addr, last_wr_data});
        end
        step();
        dma_write = 1'b0;
        mid();
        n_cmp++;
        if (dma_ack !== 1'b0) begin
            n_err++;
            $display("FAIL wr_after: ack got %b want 0", dma_ack);
        end
    endtask

    task automatic test_starvation();
        step();
        cpu_mem_enable = 1'b1;
        cpu_mem_mode   = MEM_MODE_READ;
        cpu_addr       = 16'h2000;
        dma_req        = 1'b1;
        dma_write      = 1'b0;
        dma_addr       = 16'h0099;
        mid();
`ifdef K12A_ARB_STARVE_EN
        for (int i = 1; i <= 3; i++) begin
            step();
            mid();
            n_cmp++;
            if ({cpu_stall, dma_ack, mem_addr} !== {1'b0, 1'b0, 16'h2000}) begin
                n_err++;
                $display("FAIL starve_cpu_owns[%0d]: got %h want 02000", i, {cpu_stall, dma_ack, mem_addr});
            end
        end
        step();
        mid();
        n_cmp++;
        if ({cpu_stall, dma_ack, mem_enable, mem_mode, mem_addr, cpu_rdata} !==
            {1'b1, 1'b0, 1'b1, MEM_MODE_READ, 16'h0099, 8'h5A}) begin
            n_err++;
            $display("FAIL starve_steal: got %h want %h", {cpu_stall, dma_ack, mem_enable, mem_mode, mem_addr, cpu_rdata},
                     {1'b1, 1'b0, 1'b1, MEM_MODE_READ, 16'h0099, 8'h5A});
        end
        step();
        dma_req = 1'b0;
        mid();
        n_cmp++;
        if ({dma_ack, cpu_stall, dma_rdata, mem_addr} !== {1'b1, 1'b0, 8'h5A, 16'h2000}) begin
            n_err++;
            $display("FAIL starve_ack: got %h want %h", {dma_ack, cpu_stall, dma_rdata, mem_addr},
                     {1'b1, 1'b0, 8'h5A, 16'h2000});
        end
        step();
        cpu_mem_enable = 1'b0;
        mid();
`else
        for (int i = 1; i <= 20; i++) begin
            step();
            mid();
            n_cmp++;
            if ({cpu_stall, dma_ack, mem_addr} !== {1'b0, 1'b0, 16'h2000}) begin
                n_err++;
                $display("FAIL nostarve_wait[%0d]: got %h want 02000", i, {cpu_stall, dma_ack, mem_addr});
            end
        end
        step();
        cpu_mem_enable = 1'b0;
        mid();
        n_cmp++;
        if ({mem_enable, mem_addr, cpu_stall} !== {1'b1, 16'h0099, 1'b0}) begin
            n_err++;
            $display("FAIL nostarve_grant: got %h want %h", {mem_enable, mem_addr, cpu_stall}, {1'b1, 16'h0099, 1'b0});
        end
        step();
        dma_req = 1'b0;
        mid();
        n_cmp++;
        if ({dma_ack, dma_rdata} !== {1'b1, 8'h5A}) begin
            n_err++;
            $display("FAIL nostarve_ack: ack/rdata got %h want 15a", {dma_ack, dma_rdata});
        end
        step();
        mid();
`endif
        n_cmp++;
        if ({dma_ack, cpu_stall} !== 2'b00) begin
            n_err++;
            $display("FAIL starve_after: ack/stall got %b want 00", {dma_ack, cpu_stall});
        end
    endtask

    task automatic test_abandon();
        step();
        cpu_mem_enable = 1'b0;
        dma_req        = 1'b1;
        dma_write      = 1'b0;
        dma_addr       = 16'h1234;
        mid();
        step();
        dma_req = 1'b0;
        mid();
        n_cmp++;
        if ({mem_enable, dma_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL abandon_wait: en/ack got %b want 00", {mem_enable, dma_ack});
        end
        step();
        dma_req = 1'b1;
        mid();
        n_cmp++;
        if ({mem_enable, dma_ack} !== 2'b00) begin
            n_err++;
            $display("FAIL abandon_idle: en/ack got %b want 00", {mem_enable, dma_ack});
        end
        step();
        mid();
        n_cmp++;
        if ({mem_enable, mem_addr, dma_ack} !== {1'b1, 16'h1234, 1'b0}) begin
            n_err++;
            $display("FAIL abandon_restart: got %h want %h", {mem_enable, mem_addr, dma_ack}, {1'b1, 16'h1234, 1'b0});
        end
        step();
        dma_req = 1'b0;
        mid();
        n_cmp++;
        if ({dma_ack, dma_rdata} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL abandon_ack: ack/rdata got %h want 1a5", {dma_ack, dma_rdata});
        end
    endtask

    task automatic test_reset_mid();
        step();
        cpu_mem_enable = 1'b0;
        dma_req        = 1'b1;
        dma_write      = 1'b0;
        dma_addr       = 16'h0099;
        mid();
        step();
        reset_n = 1'b0;
        mid();
        n_cmp++;
        if ({mem_enable, dma_ack, cpu_stall} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_wait: en/ack/stall got %b want 000", {mem_enable, dma_ack, cpu_stall});
        end
        step();
        mid();
        n_cmp++;
        if ({mem_enable, dma_ack, cpu_stall, dma_rdata} !== {3'b000, 8'h00}) begin
            n_err++;
            $display("FAIL rstmid_held: en/ack/stall/rdata got %h want 000", {mem_enable, dma_ack, cpu_stall, dma_rdata});
        end
        step();
        reset_n = 1'b1;
        dma_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            n_cmp++;
            if ({dma_ack, dma_rdata} !== {1'b0, 8'h00}) begin
                n_err++;
                $display("FAIL rstmid_noack[%0d]: ack/rdata got %h want 000", i, {dma_ack, dma_rdata});
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int first_ack;
        int second_ack;
        int n_acks;
        first_ack  = -1;
        second_ack = -1;
        n_acks     = 0;
        step();
        cpu_mem_enable = 1'b0;
        dma_req        = 1'b1;
        dma_write      = 1'b0;
        dma_addr       = 16'h1234;
        for (int c = 0; c < 9; c++) begin
            if (c != 0) begin
                step();
            end
            mid();
            if (dma_ack === 1'b1) begin
                if (n_acks == 0) first_ack = c;
                if (n_acks == 1) second_ack = c;
                n_acks++;
            end
        end
        step();
        dma_req = 1'b0;
        n_cmp++;
        if (n_acks != 3) begin
            n_err++;
            $display("FAIL b2b_count: acks got %0d want 3", n_acks);
        end
        n_cmp++;
        if (first_ack != 2) begin
            n_err++;
            $display("FAIL b2b_first: cycle got %0d want 2", first_ack);
        end
        n_cmp++;
        if (second_ack - first_ack != 3) begin
            n_err++;
            $display("FAIL b2b_spacing: cycles got %0d want 3", second_ack - first_ack);
        end
        mid();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_dma_read();
        test_dma_write();
        test_starvation();
        test_abandon();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/k12a_mem_arbiter.md
K12A_MEM_ARBITER -- requirements
Module: k12a_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive CPU-blocked DMA wait cycles before a forced steal; legal range 1..15.
REQ-002 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset; synchronous and active-low.
REQ-004 cpu_mem_enable  input  1  CPU requests memory this cycle.
REQ-005 cpu_mem_mode  input  mem_mode_t  CPU access direction (MEM_MODE_READ/MEM_MODE_WRITE).
REQ-006 cpu_addr  input  16  CPU address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_rdata  output  8  memory read data to the CPU.
REQ-009 cpu_stall  output  1  CPU FSM SHALL hold state (no register or state update) while high.
REQ-010 dma_req  input  1  DMA requests one access.
REQ-011 dma_write  input  1  DMA direction, 1 = write.
REQ-012 dma_addr  input  16  DMA address.
REQ-013 dma_wdata  input  8  DMA write data.
REQ-014 dma_ack  output  1  one-cycle completion pulse.
REQ-015 dma_rdata  output  8  registered DMA read data.
REQ-016 mem_enable  output  1  memory select.
REQ-017 mem_mode  output  mem_mode_t  memory direction.
REQ-018 mem_addr  output  16  memory address.
REQ-019 mem_wdata  output  8  memory write data.
REQ-020 mem_rdata  input  8  memory read data, combinationally valid in the same cycle.

Function
REQ-021 States: IDLE, WAIT, DONE; state register plus a 4-bit starve counter.
REQ-022 IDLE: dma_req=1 -> WAIT next cycle; no DMA bus access occurs in IDLE.
REQ-023 WAIT, cpu_mem_enable=0: DMA owns the bus this cycle (mem_* driven from dma_*); mem_rdata captured into dma_rdata on a read; next state DONE; counter cleared.
REQ-024 WAIT, cpu_mem_enable=1, no steal: CPU owns the bus; state stays WAIT; counter increments, saturating at 15.
REQ-025 Steal: in WAIT with counter == STARVE_LIMIT-1 and cpu_mem_enable=1, cpu_stall=1 and the DMA owns the bus exactly as in REQ-023.
REQ-026 WAIT with dma_req=0: transaction abandoned; no access; next state IDLE; counter cleared; no ack.
REQ-027 DONE: dma_ack=1 for exactly this cycle; next state IDLE unconditionally; a still-high dma_req starts a new transaction (minimum 3 cycles per access).
REQ-028 Without a DMA grant: mem_enable=cpu_mem_enable, mem_mode=cpu_mem_mode, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
REQ-029 cpu_rdata=mem_rdata combinationally at all times.
REQ-030 cpu_stall SHALL be 0 in all cases other than REQ-025.
REQ-031 dma_rdata holds its value until the next DMA read; it is unchanged by DMA writes.
REQ-032 dma_addr, dma_wdata and dma_write SHALL be held stable by the requester from dma_req rise until dma_ack.

Reset
REQ-033 While reset_n=0 at a clock edge: state<=IDLE, counter<=0, dma_rdata<=8'h00.
REQ-034 While reset_n=0: dma_ack=0, cpu_stall=0, mem_enable=0.
REQ-035 Reset mid-transaction (WAIT or DONE) abandons the transaction; no ack is issued afterwards.

Configuration
REQ-036 Macro K12A_ARB_STARVE_EN defined: the counter and the REQ-025 steal are implemented.
REQ-037 Macro K12A_ARB_STARVE_EN undefined: no counter; cpu_stall is tied to 0; the DMA waits indefinitely for a CPU-idle cycle; STARVE_LIMIT is ignored.

Verification
REQ-038 The bench SHALL cover the following scenarios, with the stated responses:
- Scenario 1, DMA read on an idle CPU: dma_req=1, dma_addr=16'h1234, mem holds 8'hA5 -> WAIT access next cycle with mem_addr=16'h1234; dma_ack pulses the following cycle; dma_rdata=8'hA5.
- Scenario 2, DMA write: dma_write=1, dma_addr=16'h0040, dma_wdata=8'h3C, CPU idle -> one cycle with mem_enable=1, mem_mode=WRITE, mem_addr=16'h0040, mem_wdata=8'h3C; then ack.
- Scenario 3, starvation: K12A_ARB_STARVE_EN defined, STARVE_LIMIT=4, cpu_mem_enable held 1 -> CPU owns the bus for 3 WAIT cycles; the 4th WAIT cycle has cpu_stall=1 with the DMA owning the bus; ack follows. Without the macro, no ack ever issues and cpu_stall stays 0.
- Scenario 4, abandon: dma_req dropped during WAIT -> no memory access, no ack, IDLE next cycle.
- Scenario 5, reset mid-operation: reset_n=0 during WAIT -> IDLE; dma_ack=0; dma_rdata=8'h00; mem_enable=0 while reset is held.
- Scenario 6, back-to-back: dma_req held high across two transactions -> acks spaced exactly 3 cycles apart with the CPU idle.
